// File: rtl/conv_scan_ctrl_if.sv
// Interface bundling the control inputs and scan outputs of conv_scan_ctrl.
// master: the sequencer side; slave: the host/datapath side.
interface conv_scan_ctrl_if;
    logic        start;
    logic        clr;
    logic        hold;
    logic [3:0]  w_raddr;
    logic        w_load;
    logic [3:0]  w_load_idx;
    logic [1:0]  x;
    logic [1:0]  y;
    logic [4:0]  X;
    logic [4:0]  Y;
    logic        valid;
    logic        x_step;
    logic        y_step;
    logic        pos_step;
    logic        row_wrap;
    logic        busy;
    logic        finish;
    logic [23:0] cycle_cnt;

    modport master (
        input  start, clr, hold,
        output w_raddr, w_load, w_load_idx, x, y, X, Y, valid,
               x_step, y_step, pos_step, row_wrap, busy, finish, cycle_cnt
    );

    modport slave (
        output start, clr, hold,
        input  w_raddr, w_load, w_load_idx, x, y, X, Y, valid,
               x_step, y_step, pos_step, row_wrap, busy, finish, cycle_cnt
    );
endinterface

// File: rtl/conv_scan_ctrl.sv
// Kernel-load then output-plane scan sequencer for the 3x3 conv datapath.
// Define CONV_SCAN_CYCLE_CNT_EN to build the saturating RUN cycle counter.
module conv_scan_ctrl #(
    parameter int unsigned K      = 3,
    parameter int unsigned N      = 19,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned NBANK  = 16
) (
    input  logic             clk,
    input  logic             xrst,
    conv_scan_ctrl_if.master bus
);
    localparam int unsigned KK     = K * K;
    localparam int unsigned LD_CYC = KK + RD_LAT;
    localparam int unsigned LDW    = $clog2(LD_CYC + 1);
    localparam int unsigned AW     = $clog2(NBANK);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [LDW-1:0]            ld_cnt_q, ld_cnt_d;
    logic [RD_LAT-1:0]         ld_vld_q;
    logic [RD_LAT-1:0][AW-1:0] ld_idx_q;
    logic [1:0]                x_q, y_q, x_d, y_d;
    logic [4:0]                X_q, Y_q, X_d, Y_d;

    logic          issue, ld_last, beat;
    logic          x_last, y_last, X_last, Y_last, scan_last;
    logic [AW-1:0] raddr;

    always_comb begin
        issue   = (state_q == LOAD) && (ld_cnt_q < LDW'(KK));
        ld_last = (state_q == LOAD) && (ld_cnt_q == LDW'(LD_CYC - 1));
        raddr   = '0;
        if (state_q == LOAD) begin
            raddr = issue ? AW'(ld_cnt_q) : AW'(KK - 1);
        end
        beat      = (state_q == RUN) && !bus.hold;
        x_last    = (x_q == 2'(K - 1));
        y_last    = (y_q == 2'(K - 1));
        X_last    = (X_q == 5'(N - 1));
        Y_last    = (Y_q == 5'(N - 1));
        scan_last = x_last && y_last && X_last && Y_last;
    end

    // Counters ripple x->y->X->Y; the final beat wraps all to zero for DONE.
    always_comb begin
        ld_cnt_d = '0;
        if (state_q == LOAD && !ld_last && !bus.clr) begin
            ld_cnt_d = ld_cnt_q + 1'b1;
        end
        x_d = x_q;
        y_d = y_q;
        X_d = X_q;
        Y_d = Y_q;
        if (bus.clr || state_q != RUN) begin
            x_d = '0;
            y_d = '0;
            X_d = '0;
            Y_d = '0;
        end else if (beat) begin
            x_d = x_last ? '0 : x_q + 1'b1;
            if (x_last) begin
                y_d = y_last ? '0 : y_q + 1'b1;
                if (y_last) begin
                    X_d = X_last ? '0 : X_q + 1'b1;
                    if (X_last) begin
                        Y_d = Y_last ? '0 : Y_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    if (ld_last) state_d = RUN;
            RUN:     if (beat && scan_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.clr) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            ld_cnt_q <= '0;
            ld_vld_q <= '0;
            ld_idx_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            X_q      <= '0;
            Y_q      <= '0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            X_q      <= X_d;
            Y_q      <= Y_d;
            if (bus.clr) begin
                ld_vld_q <= '0;
                ld_idx_q <= '0;
            end else begin
                ld_vld_q[0] <= issue;
                ld_idx_q[0] <= raddr;
                for (int unsigned i = 1; i < RD_LAT; i++) begin
                    ld_vld_q[i] <= ld_vld_q[i-1];
                    ld_idx_q[i] <= ld_idx_q[i-1];
                end
            end
        end
    end

`ifdef CONV_SCAN_CYCLE_CNT_EN
    logic [23:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == IDLE && bus.start && !bus.clr) begin
            cyc_d = '0;
        end else if (state_q == RUN && cyc_q != '1) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign bus.cycle_cnt = cyc_q;
`else
    assign bus.cycle_cnt = '0;
`endif

    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.finish     = (state_q == DONE);
        bus.w_raddr    = raddr;
        bus.w_load     = ld_vld_q[RD_LAT-1];
        bus.w_load_idx = ld_vld_q[RD_LAT-1] ? ld_idx_q[RD_LAT-1] : '0;
        bus.x          = x_q;
        bus.y          = y_q;
        bus.X          = X_q;
        bus.Y          = Y_q;
        bus.valid      = beat;
        bus.x_step     = beat && !x_last;
        bus.y_step     = beat && x_last && !y_last;
        bus.pos_step   = beat && x_last && y_last;
        bus.row_wrap   = beat && x_last && y_last && X_last;
    end
endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Self-checking bench for conv_scan_ctrl: beat-index reference model, random stalls.
module tb_conv_scan_ctrl;
  localparam int K      = 3;
  localparam int N      = 19;
  localparam int RD_LAT = 1;
  localparam int KK     = K * K;
  localparam int LD     = KK + RD_LAT;
  localparam int TOTAL  = N * N * KK;
`ifdef CONV_SCAN_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic xrst;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   sim_done = 1'b0;

  conv_scan_ctrl_if bus();

  conv_scan_ctrl #(.K(K), .N(N), .RD_LAT(RD_LAT), .NBANK(16)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    if (!sim_done) begin
      n_err++;
      $error("FAIL TIMEOUT: simulation did not complete within the wait limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"},     bus.busy,       0);
    chk({tag, ".finish"},   bus.finish,     0);
    chk({tag, ".valid"},    bus.valid,      0);
    chk({tag, ".w_load"},   bus.w_load,     0);
    chk({tag, ".w_idx"},    bus.w_load_idx, 0);
    chk({tag, ".w_raddr"},  bus.w_raddr,    0);
    chk({tag, ".x"},        bus.x,          0);
    chk({tag, ".y"},        bus.y,          0);
    chk({tag, ".X"},        bus.X,          0);
    chk({tag, ".Y"},        bus.Y,          0);
    chk({tag, ".x_step"},   bus.x_step,     0);
    chk({tag, ".y_step"},   bus.y_step,     0);
    chk({tag, ".pos_step"}, bus.pos_step,   0);
    chk({tag, ".row_wrap"}, bus.row_wrap,   0);
    chk({tag, ".cnt"},      bus.cycle_cnt,  0);
  endtask

  // One scan from IDLE. Beat b maps to taps/position by plain division.
  task automatic scan(input string tag, input int hold_beat, input int hold_len,
                      input int rnd_pct, input int clr_beat, input bit start_hold);
    int b = 0, stall_left = 0, run_cyc = 0, stalls = 0;
    int nval = 0, npos = 0, nrow = 0, nfin = 0, fin_at = -1, cyc = 0;
    int e_xs, e_ys, e_ps, e_rw, li;
    bit h, hold_used = 0, do_clr;

    bus.start = 1'b1; bus.clr = 1'b0; bus.hold = 1'b0;
    @(negedge clk);
    chk({tag, ".idle_busy"}, bus.busy, 0);
    next_cycle(); cyc++;
    if (!start_hold) bus.start = 1'b0;

    for (int c = 1; c <= LD; c++) begin
      bus.hold = 1'($urandom_range(0, 1));
      @(negedge clk);
      li = c - 1 - RD_LAT;
      chk({tag, ".ld_busy"},  bus.busy,    1);
      chk({tag, ".ld_valid"}, bus.valid,   0);
      chk({tag, ".ld_raddr"}, bus.w_raddr, (c - 1 < KK) ? c - 1 : KK - 1);
      chk({tag, ".ld_wload"}, bus.w_load,  (li >= 0 && li < KK) ? 1 : 0);
      if (li >= 0 && li < KK) chk({tag, ".ld_idx"}, bus.w_load_idx, li);
      chk({tag, ".ld_cnt"},   bus.cycle_cnt, 0);
      nfin += int'(bus.finish);
      next_cycle(); cyc++;
    end

    while (b < TOTAL) begin
      if (b == hold_beat && !hold_used) begin
        stall_left = hold_len;
        hold_used  = 1'b1;
      end
      if (stall_left > 0) begin
        h = 1'b1;
        stall_left--;
      end else begin
        h = ($urandom_range(0, 99) < rnd_pct);
      end
      do_clr   = (b == clr_beat) && !h;
      bus.hold = h;
      bus.clr  = do_clr;
      if (do_clr) bus.start = 1'b1;
      @(negedge clk);
      run_cyc++;
      if (h) stalls++;
      e_xs = (!h && (b % K != K - 1)) ? 1 : 0;
      e_ys = (!h && (b % K == K - 1) && ((b / K) % K != K - 1)) ? 1 : 0;
      e_ps = (!h && (b % KK == KK - 1)) ? 1 : 0;
      e_rw = (e_ps == 1 && (b / KK) % N == N - 1) ? 1 : 0;
      chk({tag, ".x"},        bus.x,        b % K);
      chk({tag, ".y"},        bus.y,        (b / K) % K);
      chk({tag, ".X"},        bus.X,        (b / KK) % N);
      chk({tag, ".Y"},        bus.Y,        b / (KK * N));
      chk({tag, ".valid"},    bus.valid,    h ? 0 : 1);
      chk({tag, ".x_step"},   bus.x_step,   e_xs);
      chk({tag, ".y_step"},   bus.y_step,   e_ys);
      chk({tag, ".pos_step"}, bus.pos_step, e_ps);
      chk({tag, ".row_wrap"}, bus.row_wrap, e_rw);
      nval += int'(bus.valid);
      npos += int'(bus.pos_step);
      nrow += int'(bus.row_wrap);
      nfin += int'(bus.finish);
      next_cycle(); cyc++;
      if (do_clr) begin
        bus.clr = 1'b0; bus.start = 1'b0; bus.hold = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk({tag, ".clr_busy"},  bus.busy,   0);
          chk({tag, ".clr_valid"}, bus.valid,  0);
          chk({tag, ".clr_X"},     bus.X,      0);
          nfin += int'(bus.finish);
          next_cycle();
        end
        chk({tag, ".clr_nfin"}, nfin, 0);
        return;
      end
      if (!h) b++;
    end

    bus.hold = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (bus.finish === 1'b1 && fin_at < 0) fin_at = cyc;
    nfin += int'(bus.finish);
    chk({tag, ".done_fin"},   bus.finish, 1);
    chk({tag, ".done_valid"}, bus.valid,  0);
    chk({tag, ".done_busy"},  bus.busy,   1);
    chk({tag, ".done_xyXY"},  {bus.x, bus.y, bus.X, bus.Y}, 0);
    chk({tag, ".done_cnt"},   bus.cycle_cnt, CNT_EN ? run_cyc : 0);
    next_cycle(); cyc++;

    bus.hold = 1'b0;
    @(negedge clk);
    nfin += int'(bus.finish);
    chk({tag, ".idle_busy2"}, bus.busy,      0);
    chk({tag, ".idle_cnt"},   bus.cycle_cnt, CNT_EN ? run_cyc : 0);
    next_cycle(); cyc++;

    chk({tag, ".n_valid"},  nval,   TOTAL);
    chk({tag, ".n_pos"},    npos,   N * N);
    chk({tag, ".n_row"},    nrow,   N);
    chk({tag, ".n_finish"}, nfin,   1);
    chk({tag, ".fin_at"},   fin_at, 1 + (KK + RD_LAT) + TOTAL + stalls);

    if (start_hold) begin
      @(negedge clk);
      chk({tag, ".restart_busy"},  bus.busy,      1);
      chk({tag, ".restart_raddr"}, bus.w_raddr,   0);
      chk({tag, ".restart_cnt"},   bus.cycle_cnt, 0);
      bus.start = 1'b0;
      bus.clr   = 1'b1;
      next_cycle();
      bus.clr = 1'b0;
      @(negedge clk);
      chk({tag, ".abort_busy"}, bus.busy, 0);
      next_cycle();
    end
  endtask

  initial begin
    xrst = 1'b0;
    bus.start = 1'b1; bus.clr = 1'b0; bus.hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("T1_rst");
    @(posedge clk); #1;
    bus.start = 1'b0;
    xrst = 1'b1;
    next_cycle();
    @(negedge clk);
    chk_quiet("T1_rel");
    next_cycle();

    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    repeat (20) next_cycle();
    chk("ARST.pre_busy",  bus.busy,  1);
    chk("ARST.pre_valid", bus.valid, 1);
    #2 xrst = 1'b0;
    #1;
    chk_quiet("ARST");
    @(posedge clk); #1;
    xrst = 1'b1;
    next_cycle();

    scan("T3",   -1,     0, 0,  -1,      1'b0);
    scan("T4",   43,     5, 0,  -1,      1'b0);
    scan("RND",  -1,     0, 10, -1,      1'b0);
    scan("T5",   -1,     0, 0,  10 * KK, 1'b0);
    scan("T5b",  -1,     0, 0,  -1,      1'b0);
    scan("T6",   -1,     0, 0,  -1,      1'b1);

    sim_done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
